morph_frame_ctrl: RTL and testbench

Frame-synchronous controller for the 1-bit morphology pipeline: two cascaded 3x3 stages, each selectable as bypass, erosion or dilation. It accepts a mode request from the host over a valid/ready handshake, holds it pending, and applies it only at the next frame start, so a frame is never processed with mixed settings. It also tracks frame activity, counts completed frames and, optionally, checks incoming frame geometry. It sits beside the morphology datapath and observes the same vsync/href/clken stream that feeds stage 1.

---
 rtl/morph_frame_ctrl_if.sv | 10 +
 rtl/morph_frame_ctrl.sv | 135 +++++++++++++
 tb/tb_morph_frame_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/morph_frame_ctrl_if.sv
// Host configuration channel for morph_frame_ctrl: mode request handshake plus error pulse.
interface morph_frame_ctrl_if;
  logic       cfg_valid;
  logic [2:0] cfg_mode;
  logic       cfg_ready;
  logic       cfg_err;

  modport master (output cfg_valid, output cfg_mode, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_mode, output cfg_ready, output cfg_err);
endinterface

// File: rtl/morph_frame_ctrl.sv
// Frame-synchronous mode controller for the two-stage 1-bit morphology pipeline.
// Optional geometry checking is compiled in with `define MORPH_GEOM_CHECK_EN.
module morph_frame_ctrl #(
  parameter logic [9:0] IMG_HDISP = 10'd640,
  parameter logic [9:0] IMG_VDISP = 10'd480
) (
  input  logic                clk,
  input  logic                rst,
  morph_frame_ctrl_if.slave   cfg,
  input  logic                per_frame_vsync,
  input  logic                per_frame_href,
  input  logic                per_frame_clken,
  output logic [1:0]          stage1_sel,
  output logic [1:0]          stage2_sel,
  output logic [2:0]          active_mode,
  output logic                frame_busy,
  output logic                frame_done,
  output logic                geom_err,
  output logic [15:0]         frame_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, CHECK} state_t;

  state_t     state, state_next;
  logic       vs_d;
  logic       vs_rise, vs_fall;
  logic       pending_flag;
  logic [2:0] pending_mode;
  logic       cfg_err_q;
  logic       xfer, legal;

  assign vs_rise = per_frame_vsync && !vs_d;
  assign vs_fall = !per_frame_vsync && vs_d;
  assign legal   = (cfg.cfg_mode <= 3'd4);
  assign xfer    = cfg.cfg_valid && cfg.cfg_ready;

  assign cfg.cfg_ready = !pending_flag;
  assign cfg.cfg_err   = cfg_err_q;
  assign frame_busy    = (state == ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (vs_rise) state_next = ACTIVE;
      ACTIVE:  if (vs_fall) state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A transfer can never coincide with consumption: cfg_ready is low whenever a request is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d         <= 1'b1;
      pending_flag <= 1'b0;
      pending_mode <= 3'd0;
      active_mode  <= 3'd0;
      cfg_err_q    <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= 16'd0;
    end else begin
      vs_d       <= per_frame_vsync;
      cfg_err_q  <= xfer && !legal;
      frame_done <= (state == CHECK);
      if (state == CHECK)
        frame_cnt <= frame_cnt + 16'd1;
      if (state == IDLE && vs_rise && pending_flag) begin
        active_mode  <= pending_mode;
        pending_flag <= 1'b0;
      end else if (xfer && legal) begin
        pending_mode <= cfg.cfg_mode;
        pending_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    stage1_sel = 2'b00;
    stage2_sel = 2'b00;
    case (active_mode)
      3'd1:    stage1_sel = 2'b01;
      3'd2:    stage1_sel = 2'b10;
      3'd3:    begin stage1_sel = 2'b01; stage2_sel = 2'b10; end
      3'd4:    begin stage1_sel = 2'b10; stage2_sel = 2'b01; end
      default: ;
    endcase
  end

`ifdef MORPH_GEOM_CHECK_EN
  logic       hs_d;
  logic       hs_fall;
  logic       pixel;
  logic [9:0] col_cnt;
  logic [9:0] line_cnt;
  logic       err_flag;

  assign hs_fall = !per_frame_href && hs_d;
  assign pixel   = per_frame_clken && per_frame_href;

  // A pixel arriving in the same cycle as the frame start is the first of the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_d     <= 1'b1;
      col_cnt  <= 10'd0;
      line_cnt <= 10'd0;
      err_flag <= 1'b0;
      geom_err <= 1'b0;
    end else begin
      hs_d     <= per_frame_href;
      geom_err <= (state == CHECK) && (err_flag || (line_cnt != IMG_VDISP));
      if (vs_rise) begin
        col_cnt  <= pixel ? 10'd1 : 10'd0;
        line_cnt <= 10'd0;
        err_flag <= 1'b0;
      end else if (hs_fall) begin
        if (col_cnt != IMG_HDISP) err_flag <= 1'b1;
        col_cnt <= 10'd0;
        if (line_cnt != 10'h3FF) line_cnt <= line_cnt + 10'd1;
      end else if (pixel && col_cnt != 10'h3FF) begin
        col_cnt <= col_cnt + 10'd1;
      end
    end
  end
`else
  logic geom_unused;
  assign geom_unused = ^{per_frame_href, per_frame_clken, IMG_HDISP, IMG_VDISP};
  assign geom_err    = 1'b0;
`endif

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Scoreboard bench for morph_frame_ctrl using a reduced 8x6 frame geometry.
module tb_morph_frame_ctrl;

  localparam logic [9:0] HD = 10'd8;
  localparam logic [9:0] VD = 10'd6;

  typedef struct {
    logic [2:0]  mode;
    logic [3:0]  sel;
    logic        geom;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic        clken = 1'b0;
  logic [1:0]  stage1_sel, stage2_sel;
  logic [2:0]  active_mode;
  logic        frame_busy, frame_done, geom_err;
  logic [15:0] frame_cnt;

  int          total = 0;
  int          bad = 0;
  logic [15:0] model_cnt = 16'd0;
  exp_t        sb[$];
  exp_t        mon_e;

  morph_frame_ctrl_if cfg_bus ();

  morph_frame_ctrl #(.IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg             (cfg_bus.slave),
    .per_frame_vsync (vsync),
    .per_frame_href  (href),
    .per_frame_clken (clken),
    .stage1_sel      (stage1_sel),
    .stage2_sel      (stage2_sel),
    .active_mode     (active_mode),
    .frame_busy      (frame_busy),
    .frame_done      (frame_done),
    .geom_err        (geom_err),
    .frame_cnt       (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish (got running, need done)");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] sel_of(input logic [2:0] m);
    case (m)
      3'd1:    return 4'b01_00;
      3'd2:    return 4'b10_00;
      3'd3:    return 4'b01_10;
      3'd4:    return 4'b10_01;
      default: return 4'b00_00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_mode(input logic [2:0] m);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_mode  = m;
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  // Drives one frame; short_line < 0 means every line is full length.
  task automatic applyStimulus(input int lines, input int short_line, input bit cfg_at_rise,
                               input logic [2:0] cfg_m, input logic [2:0] exp_mode,
                               input bit exp_ready);
    exp_t e;
    int   n;
    e.mode = exp_mode;
    e.sel  = sel_of(exp_mode);
    model_cnt = model_cnt + 16'd1;
    e.cnt  = model_cnt;
`ifdef MORPH_GEOM_CHECK_EN
    e.geom = (short_line >= 0) || (lines != int'(VD));
`else
    e.geom = 1'b0;
`endif
    sb.push_back(e);

    checkOutput("busy_pre_rise", {31'd0, frame_busy}, 32'd0);
    vsync = 1'b1;
    if (cfg_at_rise) begin
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_mode  = cfg_m;
    end
    tick();
    cfg_bus.cfg_valid = 1'b0;
    checkOutput("busy_rise1", {31'd0, frame_busy}, 32'd1);
    checkOutput("sel_rise1", {28'd0, stage1_sel, stage2_sel}, {28'd0, e.sel});
    checkOutput("ready_rise1", {31'd0, cfg_bus.cfg_ready}, {31'd0, exp_ready});

    for (int l = 0; l < lines; l++) begin
      n = (l == short_line) ? int'(HD) - 1 : int'(HD);
      for (int c = 0; c < n; c++) begin
        href = 1'b1; clken = 1'b1;
        tick();
        if (c == 2) begin
          clken = 1'b0;
          tick();
        end
      end
      href = 1'b0; clken = 1'b0;
      tick();
    end
    tick();

    vsync = 1'b0;
    tick();
    checkOutput("done_fall1", {31'd0, frame_done}, 32'd0);
    tick();
    checkOutput("done_fall2", {31'd0, frame_done}, 32'd1);
    tick();
    checkOutput("done_pulse_end", {31'd0, frame_done}, 32'd0);
    checkOutput("busy_after", {31'd0, frame_busy}, 32'd0);
    tick();
  endtask

  // Frame results are compared when the DUT announces completion.
  always @(negedge clk) begin
    if (!rst && frame_done) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sb_cnt", {16'd0, frame_cnt}, {16'd0, mon_e.cnt});
        checkOutput("sb_geom", {31'd0, geom_err}, {31'd0, mon_e.geom});
        checkOutput("sb_mode", {29'd0, active_mode}, {29'd0, mon_e.mode});
        checkOutput("sb_sel", {28'd0, stage1_sel, stage2_sel}, {28'd0, mon_e.sel});
      end
    end
  end

  initial begin
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_mode  = 3'd0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
    checkOutput("rst_err", {31'd0, cfg_bus.cfg_err}, 32'd0);
    checkOutput("rst_busy", {31'd0, frame_busy}, 32'd0);
    checkOutput("rst_done", {31'd0, frame_done}, 32'd0);
    checkOutput("rst_geom", {31'd0, geom_err}, 32'd0);
    checkOutput("rst_cnt", {16'd0, frame_cnt}, 32'd0);
    checkOutput("rst_mode", {29'd0, active_mode}, 32'd0);
    checkOutput("rst_sel", {28'd0, stage1_sel, stage2_sel}, 32'd0);

    $display("[TB] open mode request then full frame");
    offer_mode(3'd3);
    checkOutput("ready_after_xfer", {31'd0, cfg_bus.cfg_ready}, 32'd0);
    checkOutput("mode_before_frame", {29'd0, active_mode}, 32'd0);
    applyStimulus(int'(VD), -1, 1'b0, 3'd0, 3'd3, 1'b1);

    $display("[TB] dilate request coinciding with frame start");
    applyStimulus(int'(VD), -1, 1'b1, 3'd2, 3'd3, 1'b0);
    applyStimulus(int'(VD), -1, 1'b0, 3'd0, 3'd2, 1'b1);

    $display("[TB] illegal mode request");
    offer_mode(3'd6);
    checkOutput("err_pulse", {31'd0, cfg_bus.cfg_err}, 32'd1);
    checkOutput("err_ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
    tick();
    checkOutput("err_pulse_end", {31'd0, cfg_bus.cfg_err}, 32'd0);
    applyStimulus(int'(VD), -1, 1'b0, 3'd0, 3'd2, 1'b1);

    $display("[TB] geometry faults");
    applyStimulus(int'(VD), 3, 1'b0, 3'd0, 3'd2, 1'b1);
    applyStimulus(int'(VD) - 1, -1, 1'b0, 3'd0, 3'd2, 1'b1);
    applyStimulus(int'(VD), -1, 1'b0, 3'd0, 3'd2, 1'b1);

    $display("[TB] reset in the middle of a frame");
    vsync = 1'b1;
    tick();
    tick();
    offer_mode(3'd1);
    checkOutput("mid_pending", {31'd0, cfg_bus.cfg_ready}, 32'd0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_cnt = 16'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("mid_busy", {31'd0, frame_busy}, 32'd0);
    end
    checkOutput("mid_ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
    checkOutput("mid_sel", {28'd0, stage1_sel, stage2_sel}, 32'd0);
    checkOutput("mid_mode", {29'd0, active_mode}, 32'd0);
    checkOutput("mid_cnt", {16'd0, frame_cnt}, 32'd0);
    vsync = 1'b0;
    repeat (3) tick();
    checkOutput("mid_busy_low", {31'd0, frame_busy}, 32'd0);
    applyStimulus(int'(VD), -1, 1'b0, 3'd0, 3'd0, 1'b1);

    $display("[TB] frame counter wrap");
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    tick();
    checkOutput("preload_cnt", {16'd0, frame_cnt}, 32'h0000FFFF);
    model_cnt = 16'hFFFF;
    applyStimulus(int'(VD), -1, 1'b0, 3'd0, 3'd0, 1'b1);

    repeat (4) tick();
    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
